// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, control-word bit map and T-state encoding for the bus CPU control unit.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned HLT = 0;
  localparam int unsigned MI  = 1;
  localparam int unsigned RI  = 2;
  localparam int unsigned RO  = 3;
  localparam int unsigned IO  = 4;
  localparam int unsigned II  = 5;
  localparam int unsigned AI  = 6;
  localparam int unsigned AO  = 7;
  localparam int unsigned EO  = 8;
  localparam int unsigned SU  = 9;
  localparam int unsigned BI  = 10;
  localparam int unsigned OI  = 11;
  localparam int unsigned CE  = 12;
  localparam int unsigned CO  = 13;
  localparam int unsigned J   = 14;
  localparam int unsigned FI  = 15;

  typedef logic [15:0] ctrl_word_t;

  localparam ctrl_word_t CW_HLT = ctrl_word_t'(1) << HLT;
  localparam ctrl_word_t CW_MI  = ctrl_word_t'(1) << MI;
  localparam ctrl_word_t CW_RI  = ctrl_word_t'(1) << RI;
  localparam ctrl_word_t CW_RO  = ctrl_word_t'(1) << RO;
  localparam ctrl_word_t CW_IO  = ctrl_word_t'(1) << IO;
  localparam ctrl_word_t CW_II  = ctrl_word_t'(1) << II;
  localparam ctrl_word_t CW_AI  = ctrl_word_t'(1) << AI;
  localparam ctrl_word_t CW_AO  = ctrl_word_t'(1) << AO;
  localparam ctrl_word_t CW_EO  = ctrl_word_t'(1) << EO;
  localparam ctrl_word_t CW_SU  = ctrl_word_t'(1) << SU;
  localparam ctrl_word_t CW_BI  = ctrl_word_t'(1) << BI;
  localparam ctrl_word_t CW_OI  = ctrl_word_t'(1) << OI;
  localparam ctrl_word_t CW_CE  = ctrl_word_t'(1) << CE;
  localparam ctrl_word_t CW_CO  = ctrl_word_t'(1) << CO;
  localparam ctrl_word_t CW_J   = ctrl_word_t'(1) << J;
  localparam ctrl_word_t CW_FI  = ctrl_word_t'(1) << FI;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } t_state_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer-side signals: step control, decoded inputs and the control word it drives.
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic       step_en;
  logic [3:0] opcode;
  logic       cf;
  logic       zf;
  ctrl_word_t ctrl_word;
  logic [2:0] t_step;
  logic       halted;

  modport master (
    output step_en, opcode, cf, zf,
    input  ctrl_word, t_step, halted
  );

  modport slave (
    input  step_en, opcode, cf, zf,
    output ctrl_word, t_step, halted
  );

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode table: T-state, opcode and flags to one control word plus last-step flag.
module microcode_rom
  import cpu_ctrl_pkg::*;
(
  input  t_state_e   t_step_i,
  input  logic [3:0] opcode_i,
  input  logic       cf_i,
  input  logic       zf_i,
  output ctrl_word_t ctrl_o,
  output logic       last_o
);

  always_comb begin
    ctrl_o = '0;
    case (t_step_i)
      T0: ctrl_o = CW_CO | CW_MI;
      T1: ctrl_o = CW_RO | CW_II | CW_CE;
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_o = CW_IO | CW_MI;
          OP_LDI: ctrl_o = CW_IO | CW_AI;
          OP_JMP: ctrl_o = CW_IO | CW_J;
          OP_JC:  ctrl_o = cf_i ? (CW_IO | CW_J) : '0;
          OP_JZ:  ctrl_o = zf_i ? (CW_IO | CW_J) : '0;
          OP_OUT: ctrl_o = CW_AO | CW_OI;
          OP_HLT: ctrl_o = CW_HLT;
          default: ctrl_o = '0;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA:         ctrl_o = CW_RO | CW_AI;
          OP_ADD, OP_SUB: ctrl_o = CW_RO | CW_BI;
          OP_STA:         ctrl_o = CW_AO | CW_RI;
          default:        ctrl_o = '0;
        endcase
      end
      T4: begin
        case (opcode_i)
          OP_ADD:  ctrl_o = CW_EO | CW_AI | CW_FI;
          OP_SUB:  ctrl_o = CW_EO | CW_AI | CW_SU | CW_FI;
          default: ctrl_o = '0;
        endcase
      end
      default: ctrl_o = '0;
    endcase
  end

  // Last active step only matters once execute has started; fetch steps never end an instruction.
  always_comb begin
    case (opcode_i)
      OP_LDA, OP_STA: last_o = (t_step_i == T3);
      OP_ADD, OP_SUB: last_o = (t_step_i == T4);
      default:        last_o = (t_step_i == T2);
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer: steps fetch/execute, latches HLT, and gates the microcode word.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter bit EARLY_END = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  control_sequencer_if.slave  bus_io
);

  t_state_e   t_q, t_d;
  logic       halted_q, halted_d;
  ctrl_word_t rom_ctrl;
  logic       rom_last;

  microcode_rom u_rom (
    .t_step_i (t_q),
    .opcode_i (bus_io.opcode),
    .cf_i     (bus_io.cf),
    .zf_i     (bus_io.zf),
    .ctrl_o   (rom_ctrl),
    .last_o   (rom_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      t_q      <= T0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    if (bus_io.step_en && !halted_q) begin
      if ((rom_ctrl & CW_HLT) != '0) begin
        halted_d = 1'b1;
        t_d      = T0;
      end else if (EARLY_END ? rom_last : (t_q == T4)) begin
        t_d = T0;
      end else begin
        t_d = t_state_e'(t_q + 3'd1);
      end
    end
  end

  always_comb begin
    if (!bus_io.step_en) begin
      bus_io.ctrl_word = '0;
    end else if (halted_q) begin
      bus_io.ctrl_word = CW_HLT;
    end else begin
      bus_io.ctrl_word = rom_ctrl;
    end
    bus_io.t_step = t_q;
    bus_io.halted = halted_q;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance per EARLY_END setting.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic clk;
  logic rst0;
  logic rst1;
  int   errors;
  int   checks;

  control_sequencer_if if0 ();
  control_sequencer_if if1 ();

  control_sequencer #(.EARLY_END(1'b0)) u_dut0 (
    .CLK    (clk),
    .RST    (rst0),
    .bus_io (if0.slave)
  );

  control_sequencer #(.EARLY_END(1'b1)) u_dut1 (
    .CLK    (clk),
    .RST    (rst1),
    .bus_io (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [15:0] cw, input logic [2:0] t,
                      input logic h);
    check({tag, ".cw"}, if0.ctrl_word, cw);
    check({tag, ".t"}, 16'(if0.t_step), 16'(t));
    check({tag, ".h"}, 16'(if0.halted), 16'(h));
  endtask

  logic [3:0]  ee_op [11];
  logic [2:0]  ee_t  [11];
  logic [15:0] ee_cw [11];

  initial begin
    errors = 0;
    checks = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.step_en = 1'b1; if0.opcode = OP_NOP; if0.cf = 1'b0; if0.zf = 1'b0;
    if1.step_en = 1'b1; if1.opcode = OP_NOP; if1.cf = 1'b0; if1.zf = 1'b0;
    tick();
    tick();
    chk0("rst", 16'h2002, 3'd0, 1'b0);
    if0.step_en = 1'b0;
    #1;
    check("rst_stepoff.cw", if0.ctrl_word, 16'h0000);
    if0.step_en = 1'b1;
    rst0 = 1'b0;
    if0.opcode = OP_ADD;
    #1;
    chk0("add_a.T0", 16'h2002, 3'd0, 1'b0);
    tick(); chk0("add_a.T1", 16'h1028, 3'd1, 1'b0);
    tick(); chk0("add_a.T2", 16'h0012, 3'd2, 1'b0);
    tick(); chk0("add_a.T3", 16'h0408, 3'd3, 1'b0);
    // Asynchronous reset mid-T3: must take effect with no clock edge.
    rst0 = 1'b1;
    #1;
    chk0("async_rst", 16'h2002, 3'd0, 1'b0);
    tick();
    rst0 = 1'b0;
    #1;
    chk0("post_rst.T0", 16'h2002, 3'd0, 1'b0);
    tick(); chk0("post_rst.T1", 16'h1028, 3'd1, 1'b0);
    tick(); chk0("add.T2", 16'h0012, 3'd2, 1'b0);
    tick(); chk0("add.T3", 16'h0408, 3'd3, 1'b0);
    tick(); chk0("add.T4", 16'h8140, 3'd4, 1'b0);
    tick(); chk0("add.wrap", 16'h2002, 3'd0, 1'b0);

    // Conditional jumps sampled combinationally in T2.
    if0.opcode = OP_JC;
    tick(); tick();
    if0.cf = 1'b0; #1; check("jc_cf0", if0.ctrl_word, 16'h0000);
    if0.cf = 1'b1; #1; check("jc_cf1", if0.ctrl_word, 16'h4010);
    if0.opcode = OP_JZ;
    if0.zf = 1'b0; #1; check("jz_zf0", if0.ctrl_word, 16'h0000);
    if0.zf = 1'b1; #1; check("jz_zf1", if0.ctrl_word, 16'h4010);
    if0.cf = 1'b0; if0.zf = 1'b0;
    tick(); chk0("jz.T3", 16'h0000, 3'd3, 1'b0);
    tick(); chk0("jz.T4", 16'h0000, 3'd4, 1'b0);
    tick(); chk0("jz.wrap", 16'h2002, 3'd0, 1'b0);

    // step_en freeze in T3 of SUB.
    if0.opcode = OP_SUB;
    tick(); tick(); chk0("sub.T2", 16'h0012, 3'd2, 1'b0);
    tick(); chk0("sub.T3", 16'h0408, 3'd3, 1'b0);
    if0.step_en = 1'b0;
    #1;
    chk0("freeze.0", 16'h0000, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk0("freeze", 16'h0000, 3'd3, 1'b0);
    end
    if0.step_en = 1'b1;
    #1;
    chk0("resume.T3", 16'h0408, 3'd3, 1'b0);
    tick(); chk0("resume.T4", 16'h8340, 3'd4, 1'b0);

    // HLT latch, freeze, and release by reset only.
    if0.opcode = OP_HLT;
    tick(); tick(); tick();
    chk0("hlt.T2", 16'h0001, 3'd2, 1'b0);
    tick();
    chk0("halted", 16'h0001, 3'd0, 1'b1);
    if0.opcode = OP_LDA;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk0("halt_hold", 16'h0001, 3'd0, 1'b1);
    end
    rst0 = 1'b1;
    #1;
    chk0("halt_clr", 16'h2002, 3'd0, 1'b0);
    tick();
    rst0 = 1'b0;

    // EARLY_END=1: LDI, STA, OUT back-to-back with no idle steps.
    ee_op = '{OP_LDI, OP_LDI, OP_LDI, OP_STA, OP_STA, OP_STA, OP_STA,
              OP_OUT, OP_OUT, OP_OUT, OP_NOP};
    ee_t  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd0};
    ee_cw = '{16'h2002, 16'h1028, 16'h0050, 16'h2002, 16'h1028, 16'h0012, 16'h0084,
              16'h2002, 16'h1028, 16'h0880, 16'h2002};
    rst1 = 1'b0;
    #1;
    for (int i = 0; i < 11; i++) begin
      if1.opcode = ee_op[i];
      #1;
      check($sformatf("ee[%0d].t", i), 16'(if1.t_step), 16'(ee_t[i]));
      check($sformatf("ee[%0d].cw", i), if1.ctrl_word, ee_cw[i]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
